// File: rtl/flash_arb_pkg.sv
// Shared definitions for the two-port SPI flash arbiter.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package flash_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWNED = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam int PORT_BOOT = 0;
    localparam int PORT_CPU  = 1;

    // Wide enough for the largest chip-select gap (255 clocks).
    localparam int GAP_CNT_W = 8;

    // Fixed-priority one-hot: the boot loader always beats the CPU.
    function automatic logic [1:0] prio_onehot(input logic [1:0] r);
        logic [1:0] g;
        g = 2'b00;
        if (r[PORT_BOOT]) begin
            g[PORT_BOOT] = 1'b1;
        end else if (r[PORT_CPU]) begin
            g[PORT_CPU] = 1'b1;
        end
        return g;
    endfunction

endpackage

// File: rtl/flash_arbiter_spi_shifter.sv
// SPI mode-0 byte engine: MSB first, sck = clock/2, 8 low/high phase pairs per byte.
// Latency: start at edge T gives done during the last high phase (cycle T+16); rx valid then.
// Backpressure: none; a start accepted in the done cycle begins the next byte with no gap.
// Ports: clock/reset_n; start + tx_byte load a byte; so is the flash data line;
//        done flags the final phase, rx_byte holds the bits shifted in; sck/si drive the flash.
module spi_shifter
    import flash_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       so,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       sck,
    output logic       si
);

    logic       active_q, active_d;
    logic [3:0] phase_q,  phase_d;
    logic       sck_q,    sck_d;
    logic       si_q,     si_d;
    logic [7:0] tx_sh_q,  tx_sh_d;
    logic [7:0] rx_sh_q,  rx_sh_d;

    always_comb begin
        active_d = active_q;
        phase_d  = phase_q;
        sck_d    = sck_q;
        si_d     = si_q;
        tx_sh_d  = tx_sh_q;
        rx_sh_d  = rx_sh_q;
        if (start) begin
            // First low phase already presents the MSB.
            active_d = 1'b1;
            phase_d  = 4'd0;
            sck_d    = 1'b0;
            tx_sh_d  = tx_byte;
            si_d     = tx_byte[7];
        end else if (active_q) begin
            if (!sck_q) begin
                // Rising sck edge: sample the flash on the same clock edge.
                sck_d   = 1'b1;
                rx_sh_d = {rx_sh_q[6:0], so};
                phase_d = phase_q + 4'd1;
            end else if (phase_q == 4'd15) begin
                active_d = 1'b0;
                sck_d    = 1'b0;
                si_d     = 1'b0;
                phase_d  = 4'd0;
            end else begin
                // si only moves when sck falls.
                sck_d   = 1'b0;
                tx_sh_d = {tx_sh_q[6:0], 1'b0};
                si_d    = tx_sh_q[6];
                phase_d = phase_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            phase_q  <= 4'd0;
            sck_q    <= 1'b0;
            si_q     <= 1'b0;
            tx_sh_q  <= 8'h00;
            rx_sh_q  <= 8'h00;
        end else begin
            active_q <= active_d;
            phase_q  <= phase_d;
            sck_q    <= sck_d;
            si_q     <= si_d;
            tx_sh_q  <= tx_sh_d;
            rx_sh_q  <= rx_sh_d;
        end
    end

    assign done    = active_q && sck_q && (phase_q == 4'd15);
    assign rx_byte = rx_sh_q;
    assign sck     = sck_q;
    assign si      = si_q;

endmodule

// File: rtl/flash_arbiter.sv
// Two-port non-preemptive SPI flash arbiter (boot loader > CPU) with chip-select gap.
// Latency: grant one edge after req; 17 clocks per byte from accept to next accept.
// Backpressure: tx_ready low while a byte shifts and for the non-granted port.
// Ports: clock/reset_n; req/gnt session handshake; tx_data/tx_valid/tx_ready per-port bytes;
//        rx_data/rx_valid received bytes; flash_so/si/sck/cs_n SPI pins; busy = not idle.
module flash_arbiter
    import flash_arb_pkg::*;
#(
    parameter int unsigned CS_GAP = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [15:0] tx_data,
    input  logic [1:0]  tx_valid,
    output logic [1:0]  tx_ready,
    output logic [7:0]  rx_data,
    output logic [1:0]  rx_valid,
    input  logic        flash_so,
    output logic        flash_si,
    output logic        flash_sck,
    output logic        flash_cs_n,
    output logic        busy
);

    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(CS_GAP);

    state_t               state_q,    state_d;
    logic [1:0]           gnt_q,      gnt_d;
    logic [1:0]           tx_ready_q, tx_ready_d;
    logic [1:0]           rx_valid_q, rx_valid_d;
    logic [7:0]           rx_data_q,  rx_data_d;
    logic                 cs_n_q,     cs_n_d;
    logic [GAP_CNT_W-1:0] gap_cnt_q,  gap_cnt_d;

    logic       shift_start;
    logic       shift_done;
    logic [7:0] shift_rx;
    logic [7:0] tx_byte;

    // tx_ready is only ever set for the granted port, so a foreign tx_valid cannot match.
    assign tx_byte = gnt_q[PORT_CPU] ? tx_data[15:8] : tx_data[7:0];

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        tx_ready_d  = tx_ready_q;
        rx_valid_d  = 2'b00;
        rx_data_d   = rx_data_q;
        cs_n_d      = cs_n_q;
        gap_cnt_d   = gap_cnt_q;
        shift_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    state_d    = S_OWNED;
                    gnt_d      = prio_onehot(req);
                    tx_ready_d = prio_onehot(req);
                    cs_n_d     = 1'b0;
                end
            end
            S_OWNED: begin
                // A byte offered in the same cycle as a req drop still goes out.
                if ((tx_valid & tx_ready_q) != 2'b00) begin
                    shift_start = 1'b1;
                    state_d     = S_SHIFT;
                    tx_ready_d  = 2'b00;
                end else if ((req & gnt_q) == 2'b00) begin
                    state_d    = S_GAP;
                    gnt_d      = 2'b00;
                    tx_ready_d = 2'b00;
                    cs_n_d     = 1'b1;
                    gap_cnt_d  = GAP_LOAD;
                end
            end
            S_SHIFT: begin
                if (shift_done) begin
                    state_d    = S_OWNED;
                    rx_valid_d = gnt_q;
                    rx_data_d  = shift_rx;
                    tx_ready_d = gnt_q;
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
                if (gap_cnt_q <= GAP_CNT_W'(1)) begin
                    state_d   = S_IDLE;
                    gap_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= 2'b00;
            tx_ready_q <= 2'b00;
            rx_valid_q <= 2'b00;
            rx_data_q  <= 8'h00;
            cs_n_q     <= 1'b1;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            cs_n_q     <= cs_n_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    spi_shifter u_shifter (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (shift_start),
        .tx_byte (tx_byte),
        .so      (flash_so),
        .done    (shift_done),
        .rx_byte (shift_rx),
        .sck     (flash_sck),
        .si      (flash_si)
    );

    assign gnt        = gnt_q;
    assign tx_ready   = tx_ready_q;
    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign flash_cs_n = cs_n_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter with a mode-0 flash model returning a fixed byte.
// Latency: n/a. Backpressure: n/a.
module tb_flash_arbiter;

    localparam int CS_GAP = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [15:0] tx_data;
    logic [1:0]  tx_valid;
    logic [1:0]  tx_ready;
    logic [7:0]  rx_data;
    logic [1:0]  rx_valid;
    logic        flash_so;
    logic        flash_si;
    logic        flash_sck;
    logic        flash_cs_n;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    flash_arbiter #(.CS_GAP(CS_GAP)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .gnt        (gnt),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .flash_so   (flash_so),
        .flash_si   (flash_si),
        .flash_sck  (flash_sck),
        .flash_cs_n (flash_cs_n),
        .busy       (busy)
    );

    // Flash model: shifts flash_byte out MSB first, advancing on each falling sck.
    logic [7:0] flash_byte = 8'h00;
    logic [2:0] bit_idx = 3'd0;
    assign flash_so = flash_byte[3'd7 - bit_idx];
    always @(negedge flash_sck or posedge flash_cs_n) begin
        if (flash_cs_n) bit_idx <= 3'd0;
        else            bit_idx <= bit_idx + 3'd1;
    end

    // Free-running monitors; tasks work on differences.
    int          sck_rises = 0;
    int          cs_rises  = 0;
    int          rxv_cnt   = 0;
    logic [31:0] si_cap    = 32'h0;
    always @(posedge flash_sck) begin
        sck_rises <= sck_rises + 1;
        si_cap    <= {si_cap[30:0], flash_si};
    end
    always @(posedge flash_cs_n) cs_rises <= cs_rises + 1;
    always @(posedge clock) if ((|rx_valid) === 1'b1) rxv_cnt <= rxv_cnt + 1;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin tick(); n++; end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, n); end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; req = 2'b00; tx_valid = 2'b00; tx_data = 16'h0000;
        repeat (3) tick();
        n_cmp++; if (gnt !== 2'b00)      begin n_bad++; $display("FAIL rst_gnt: got %b want 00", gnt); end
        n_cmp++; if (tx_ready !== 2'b00) begin n_bad++; $display("FAIL rst_tx_ready: got %b want 00", tx_ready); end
        n_cmp++; if (rx_valid !== 2'b00) begin n_bad++; $display("FAIL rst_rx_valid: got %b want 00", rx_valid); end
        n_cmp++; if (rx_data !== 8'h00)  begin n_bad++; $display("FAIL rst_rx_data: got %h want 00", rx_data); end
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (flash_cs_n !== 1'b1) begin n_bad++; $display("FAIL rst_cs_n: got %b want 1", flash_cs_n); end
        n_cmp++; if (flash_sck !== 1'b0) begin n_bad++; $display("FAIL rst_sck: got %b want 0", flash_sck); end
        n_cmp++; if (flash_si !== 1'b0)  begin n_bad++; $display("FAIL rst_si: got %b want 0", flash_si); end
        reset_n = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_idle_noreq: busy=%b want 0", busy); end
    endtask

    task automatic test_single;
        int r0;
        int n = 0;
        flash_byte = 8'hA5; req = 2'b01;
        tick();
        n_cmp++; if (gnt !== 2'b01)       begin n_bad++; $display("FAIL single_gnt: got %b want 01", gnt); end
        n_cmp++; if (flash_cs_n !== 1'b0) begin n_bad++; $display("FAIL single_cs_n: got %b want 0", flash_cs_n); end
        n_cmp++; if (tx_ready !== 2'b01)  begin n_bad++; $display("FAIL single_tx_ready: got %b want 01", tx_ready); end
        n_cmp++; if (busy !== 1'b1)       begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
        r0 = sck_rises;
        tx_data = 16'h0003; tx_valid = 2'b01;
        tick();
        tx_valid = 2'b00;
        n_cmp++; if (tx_ready !== 2'b00) begin n_bad++; $display("FAIL single_ready_drop: got %b want 00", tx_ready); end
        n_cmp++; if (flash_sck !== 1'b0) begin n_bad++; $display("FAIL single_first_phase_sck: got %b want 0", flash_sck); end
        while (rx_valid === 2'b00 && n < 40) begin tick(); n++; end
        n_cmp++; if (n != 16)             begin n_bad++; $display("FAIL single_latency: got %0d want 16", n); end
        n_cmp++; if (rx_valid !== 2'b01)  begin n_bad++; $display("FAIL single_rx_valid: got %b want 01", rx_valid); end
        n_cmp++; if (rx_data !== 8'hA5)   begin n_bad++; $display("FAIL single_rx_data: got %h want a5", rx_data); end
        n_cmp++; if (flash_sck !== 1'b0)  begin n_bad++; $display("FAIL single_done_sck: got %b want 0", flash_sck); end
        n_cmp++; if (tx_ready !== 2'b01)  begin n_bad++; $display("FAIL single_ready_back: got %b want 01", tx_ready); end
        n_cmp++; if (sck_rises - r0 != 8) begin n_bad++; $display("FAIL single_sck_rises: got %0d want 8", sck_rises - r0); end
        n_cmp++; if (si_cap[7:0] !== 8'h03) begin n_bad++; $display("FAIL single_si_bits: got %h want 03", si_cap[7:0]); end
        req = 2'b00;
        tick();
        n_cmp++; if (flash_cs_n !== 1'b1) begin n_bad++; $display("FAIL single_release_cs: got %b want 1", flash_cs_n); end
        n_cmp++; if (gnt !== 2'b00)       begin n_bad++; $display("FAIL single_release_gnt: got %b want 00", gnt); end
        n_cmp++; if (rx_valid !== 2'b00)  begin n_bad++; $display("FAIL single_rx_pulse_len: got %b want 00", rx_valid); end
        n_cmp++; if (rx_data !== 8'hA5)   begin n_bad++; $display("FAIL single_rx_hold: got %h want a5", rx_data); end
        wait_idle();
    endtask

    task automatic test_priority;
        int hi = 1;
        int n = 0;
        req = 2'b11;
        tick();
        n_cmp++; if (gnt !== 2'b01)      begin n_bad++; $display("FAIL prio_first: got %b want 01", gnt); end
        n_cmp++; if (tx_ready !== 2'b01) begin n_bad++; $display("FAIL prio_ready: got %b want 01", tx_ready); end
        req = 2'b10;
        tick();
        n_cmp++; if (flash_cs_n !== 1'b1) begin n_bad++; $display("FAIL prio_release_cs: got %b want 1", flash_cs_n); end
        while (gnt !== 2'b10 && n < 40) begin
            tick(); n++;
            if (gnt !== 2'b10 && flash_cs_n === 1'b1) hi++;
        end
        n_cmp++; if (gnt !== 2'b10)       begin n_bad++; $display("FAIL prio_second: got %b want 10", gnt); end
        n_cmp++; if (flash_cs_n !== 1'b0) begin n_bad++; $display("FAIL prio_second_cs: got %b want 0", flash_cs_n); end
        n_cmp++; if (hi < CS_GAP || hi > CS_GAP + 1) begin n_bad++; $display("FAIL prio_gap: got %0d high cycles want %0d..%0d", hi, CS_GAP, CS_GAP + 1); end
        req = 2'b11;
        tick(); tick();
        n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL prio_no_preempt: got %b want 10", gnt); end
        req = 2'b00;
        tick();
        wait_idle();
    endtask

    task automatic test_back_to_back;
        int r0;
        int c0;
        int gaps[3];
        int n = 0;
        int k = 0;
        flash_byte = 8'h3C; req = 2'b01;
        tick();
        r0 = sck_rises; c0 = cs_rises;
        tx_data = 16'h0081; tx_valid = 2'b01;
        tick();
        while (k < 3 && n < 100) begin
            tick(); n++;
            if (rx_valid === 2'b01) begin
                gaps[k] = n; n = 0;
                n_cmp++; if (rx_data !== 8'h3C) begin n_bad++; $display("FAIL b2b_rx_data%0d: got %h want 3c", k, rx_data); end
                k++;
                if (k == 1)      tx_data = 16'h0042;
                else if (k == 2) tx_data = 16'h0018;
                else             tx_valid = 2'b00;
            end
        end
        n_cmp++; if (k != 3)          begin n_bad++; $display("FAIL b2b_count: got %0d bytes want 3", k); end
        n_cmp++; if (gaps[0] != 16)   begin n_bad++; $display("FAIL b2b_first: got %0d want 16", gaps[0]); end
        n_cmp++; if (gaps[1] != 17)   begin n_bad++; $display("FAIL b2b_period1: got %0d want 17", gaps[1]); end
        n_cmp++; if (gaps[2] != 17)   begin n_bad++; $display("FAIL b2b_period2: got %0d want 17", gaps[2]); end
        n_cmp++; if (sck_rises - r0 != 24) begin n_bad++; $display("FAIL b2b_sck_rises: got %0d want 24", sck_rises - r0); end
        n_cmp++; if (si_cap[23:0] !== 24'h814218) begin n_bad++; $display("FAIL b2b_si_bits: got %h want 814218", si_cap[23:0]); end
        n_cmp++; if (cs_rises != c0)  begin n_bad++; $display("FAIL b2b_cs_glitch: got %0d rises want 0", cs_rises - c0); end
        req = 2'b00;
        tick();
        wait_idle();
    endtask

    task automatic test_req_drop;
        int n = 0;
        flash_byte = 8'h96; req = 2'b01;
        tick();
        tx_data = 16'h0055; tx_valid = 2'b01;
        tick();
        tx_valid = 2'b00;
        repeat (4) tick();
        req = 2'b00;
        while (rx_valid === 2'b00 && n < 40) begin tick(); n++; end
        n_cmp++; if (n != 12)             begin n_bad++; $display("FAIL drop_latency: got %0d want 12", n); end
        n_cmp++; if (rx_valid !== 2'b01)  begin n_bad++; $display("FAIL drop_rx_valid: got %b want 01", rx_valid); end
        n_cmp++; if (rx_data !== 8'h96)   begin n_bad++; $display("FAIL drop_rx_data: got %h want 96", rx_data); end
        n_cmp++; if (flash_cs_n !== 1'b0) begin n_bad++; $display("FAIL drop_cs_during: got %b want 0", flash_cs_n); end
        tick();
        n_cmp++; if (flash_cs_n !== 1'b1) begin n_bad++; $display("FAIL drop_cs_after: got %b want 1", flash_cs_n); end
        n_cmp++; if (gnt !== 2'b00)       begin n_bad++; $display("FAIL drop_gnt_after: got %b want 00", gnt); end
        wait_idle();
    endtask

    task automatic test_reset_mid;
        int v0;
        flash_byte = 8'hFF; req = 2'b01;
        tick();
        v0 = rxv_cnt;
        tx_data = 16'h00C3; tx_valid = 2'b01;
        tick();
        tx_valid = 2'b00;
        repeat (7) tick();
        reset_n = 1'b0;
        tick();
        n_cmp++; if (flash_cs_n !== 1'b1) begin n_bad++; $display("FAIL rmid_cs_n: got %b want 1", flash_cs_n); end
        n_cmp++; if (flash_sck !== 1'b0)  begin n_bad++; $display("FAIL rmid_sck: got %b want 0", flash_sck); end
        n_cmp++; if (gnt !== 2'b00)       begin n_bad++; $display("FAIL rmid_gnt: got %b want 00", gnt); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_cmp++; if (rx_data !== 8'h00)   begin n_bad++; $display("FAIL rmid_rx_data: got %h want 00", rx_data); end
        reset_n = 1'b1;
        tick();
        n_cmp++; if (gnt !== 2'b01)       begin n_bad++; $display("FAIL rmid_regrant: got %b want 01", gnt); end
        n_cmp++; if (flash_cs_n !== 1'b0) begin n_bad++; $display("FAIL rmid_regrant_cs: got %b want 0", flash_cs_n); end
        repeat (20) tick();
        n_cmp++; if (rxv_cnt != v0)       begin n_bad++; $display("FAIL rmid_no_rx: got %0d pulses want 0", rxv_cnt - v0); end
        req = 2'b00;
        tick();
        wait_idle();
    endtask

    task automatic test_foreign_tx;
        int r0;
        int v0;
        int n = 0;
        flash_byte = 8'h81; req = 2'b01;
        tick();
        r0 = sck_rises; v0 = rxv_cnt;
        tx_data = 16'hEE00; tx_valid = 2'b10;
        tick();
        n_cmp++; if (tx_ready !== 2'b01) begin n_bad++; $display("FAIL foreign_ready: got %b want 01", tx_ready); end
        repeat (3) tick();
        n_cmp++; if (sck_rises != r0)    begin n_bad++; $display("FAIL foreign_no_shift: got %0d sck rises want 0", sck_rises - r0); end
        n_cmp++; if (rxv_cnt != v0)      begin n_bad++; $display("FAIL foreign_no_rx: got %0d pulses want 0", rxv_cnt - v0); end
        n_cmp++; if (gnt !== 2'b01)      begin n_bad++; $display("FAIL foreign_gnt: got %b want 01", gnt); end
        tx_data = 16'hEE5A; tx_valid = 2'b11;
        tick();
        tx_valid = 2'b00;
        while (rx_valid === 2'b00 && n < 40) begin tick(); n++; end
        n_cmp++; if (rx_valid !== 2'b01)    begin n_bad++; $display("FAIL foreign_rx_valid: got %b want 01", rx_valid); end
        n_cmp++; if (rx_data !== 8'h81)     begin n_bad++; $display("FAIL foreign_rx_data: got %h want 81", rx_data); end
        n_cmp++; if (si_cap[7:0] !== 8'h5A) begin n_bad++; $display("FAIL foreign_si_bits: got %h want 5a", si_cap[7:0]); end
        req = 2'b00;
        tick();
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_back_to_back();
        test_req_drop();
        test_reset_mid();
        test_foreign_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flash_arbiter.md
FLASH_ARBITER -- requirements
Module: flash_arbiter

Interface
REQ-001 Parameter CS_GAP, default 4: minimum clocks flash_cs_n SHALL stay high between sessions (legal range 1..255).
REQ-002 clock  input  1  system clock; all logic SHALL use its rising edge only.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 req  input  2  session request; bit0 = boot loader, bit1 = CPU SPI port; held high for the whole session.
REQ-005 gnt  output  2  one-hot session grant, or 0 when no session is open.
REQ-006 tx_data  input  16  byte to send; [7:0] = port0, [15:8] = port1.
REQ-007 tx_valid  input  2  per-port byte-send request.
REQ-008 tx_ready  output  2  per-port byte-accept indication.
REQ-009 rx_data  output  8  last received byte, shared by both ports.
REQ-010 rx_valid  output  2  one-cycle per-port pulse; rx_data is valid in that cycle.
REQ-011 flash_so  input  1  SPI data from the flash.
REQ-012 flash_si, flash_sck, flash_cs_n  output  1 each  SPI data to the flash, clock and chip select.
REQ-013 busy  output  1  high in every state except S_IDLE.

Function
REQ-014 The state machine SHALL have exactly four states: S_IDLE, S_OWNED, S_SHIFT and S_GAP.
REQ-015 S_IDLE: when req != 0, go to S_OWNED on the next edge. gnt SHALL be the fixed-priority one-hot of req (port0 wins). flash_cs_n SHALL go low on the same edge that gnt rises.
REQ-016 Arbitration SHALL be non-preemptive. A higher-priority req arriving during a session waits until S_GAP completes.
REQ-017 S_OWNED: tx_ready[g] = 1 for the granted port g; tx_ready of the other port = 0 and its tx_valid SHALL be ignored.
REQ-018 On tx_valid[g] & tx_ready[g] at edge T, the module SHALL latch tx_data for port g and enter S_SHIFT. tx_ready SHALL be 0 from T+1 onward.
REQ-019 S_SHIFT protocol: SPI mode 0, MSB first, sck idles low and runs at clock/2.
REQ-020 S_SHIFT timing:
  - 8 low/high phase pairs in cycles T+1..T+16.
  - flash_si changes only during low phases.
  - flash_so is sampled on each low-to-high sck edge.
REQ-021 Cycle T+17:
  - rx_valid[g] = 1 with the received byte on rx_data; flash_sck low; state back to S_OWNED.
  - tx_ready[g] = 1, so a byte offered that cycle is accepted (17 clocks per byte, back to back).
REQ-022 When req[g] is low in S_OWNED and no transfer is accepted that edge:
  - flash_cs_n goes high and gnt goes to 0.
  - Enter S_GAP for CS_GAP cycles, then S_IDLE.
REQ-023 req[g] dropping during S_SHIFT SHALL NOT abort the byte; release happens after rx_valid.
REQ-024 If tx_valid and a req drop occur in the same S_OWNED cycle, the transfer SHALL take precedence; release is evaluated again afterwards.
REQ-025 When both req bits rise in the same S_IDLE cycle, port0 SHALL be granted. Port1 SHALL be granted after port0's session and gap if it is still requesting.
REQ-026 rx_data SHALL hold its value until the next rx_valid pulse.
REQ-027 Outside S_SHIFT, flash_si SHALL be 0 and flash_sck SHALL be 0.

Reset
REQ-028 While reset_n is low at a clock edge, the following SHALL take these values on that edge:
  - state = S_IDLE, gnt = 0, tx_ready = 0, rx_valid = 0, rx_data = 8'h00, busy = 0;
  - flash_cs_n = 1, flash_sck = 0, flash_si = 0, gap counter = 0.
REQ-029 A reset in mid-byte or mid-session SHALL discard the partial byte, with no rx_valid pulse. The first grant after reset release needs no CS_GAP wait.

Structure
REQ-030 Package flash_arb_pkg SHALL hold the state encoding, the port indices (PORT_BOOT = 0, PORT_CPU = 1) and the width of the CS_GAP counter.
REQ-031 Sub-module spi_shifter SHALL contain the bit engine: start/data in, done/rx out, plus sck and si. Arbitration and chip select SHALL stay in flash_arbiter.

Verification
REQ-032 Flash model driving 0xA5: req=01, tx 0x03 → gnt=01 one cycle later, cs_n low, sck 8 rising edges, si pattern 00000011, rx_valid[0] at T+17 with rx_data=0xA5.
REQ-033 req=11 simultaneous, CS_GAP=4 → port0 served first; after port0 drops req, cs_n high ≥4 cycles, then gnt=10.
REQ-034 Port0 tx_valid held over 3 bytes → exactly 17 clocks per byte, cs_n low throughout, no sck glitch between bytes.
REQ-035 req[0] dropped at cycle T+5 of a byte → byte completes, rx_valid at T+17, cs_n high at T+18.
REQ-036 reset_n low at T+8 of a byte → cs_n=1, sck=0, gnt=0 next edge, no rx_valid; new request after reset is granted immediately.
REQ-037 Port1 tx_valid while port0 owns the bus → tx_ready[1]=0, no transfer, port0 data unaffected.
